multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// with bounded memory waits and one-cycle retire/illegal/timeout event pulses.
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           RegDst,
  output logic           ALUSrc,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           Branch,
  output logic           BranchEqual,
  output logic           BranchNotEqual,
  output logic           Jump,
  output logic [1:0]     ALUOp,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic [2:0]     state,
  output logic           retire,
  output logic           illegal,
  output logic           timeout
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_ADDI  = 3'd1,
    C_LW    = 3'd2,
    C_SW    = 3'd3,
    C_BEQ   = 3'd4,
    C_BNE   = 3'd5,
    C_J     = 3'd6,
    C_ILL   = 3'd7
  } class_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  // Full-width compare so any nonzero upper opcode bit falls through to illegal.
  function automatic class_t decode_op(input logic [OPW-1:0] op);
    class_t c;
    case (op)
      OPW'(6'h00): c = C_RTYPE;
      OPW'(6'h08): c = C_ADDI;
      OPW'(6'h23): c = C_LW;
      OPW'(6'h2B): c = C_SW;
      OPW'(6'h04): c = C_BEQ;
      OPW'(6'h05): c = C_BNE;
      OPW'(6'h02): c = C_J;
      default:     c = C_ILL;
    endcase
    return c;
  endfunction

  state_t     state_r;
  class_t     class_r;
  logic [7:0] cnt_r;
  class_t     dec_s;
  logic       rdy_s;
  logic       wait_s;
  logic       tmo_s;

  // Reset masks mem_ready so no load strobe can fire while rst is low.
  assign dec_s  = decode_op(opcode);
  assign rdy_s  = mem_ready & rst;
  assign wait_s = (state_r == FETCH) || (state_r == MEMORY);
  assign tmo_s  = wait_s & rst & ~mem_ready & (cnt_r == WAIT_LAST);
  assign state  = state_r;

  // Sequencer: state, latched instruction class and memory wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FETCH;
      class_r <= C_ILL;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        FETCH: begin
          if (rdy_s) begin
            state_r <= DECODE;
            cnt_r   <= 8'd0;
          end else if (tmo_s) begin
            state_r <= FETCH;
            cnt_r   <= 8'd0;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        DECODE: begin
          class_r <= dec_s;
          cnt_r   <= 8'd0;
          if (dec_s == C_J || dec_s == C_ILL) state_r <= FETCH;
          else                                state_r <= EXECUTE;
        end
        EXECUTE: begin
          cnt_r <= 8'd0;
          case (class_r)
            C_RTYPE, C_ADDI: state_r <= WRITEBACK;
            C_LW, C_SW:      state_r <= MEMORY;
            default:         state_r <= FETCH;
          endcase
        end
        MEMORY: begin
          if (rdy_s) begin
            state_r <= (class_r == C_LW) ? WRITEBACK : FETCH;
            cnt_r   <= 8'd0;
          end else if (tmo_s) begin
            state_r <= FETCH;
            cnt_r   <= 8'd0;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        WRITEBACK: begin
          state_r <= FETCH;
          cnt_r   <= 8'd0;
        end
        default: begin
          state_r <= FETCH;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  // Strobe decode from the registered state; load/complete strobes follow mem_ready in-cycle.
  always_comb begin
    RegDst         = 1'b0;
    ALUSrc         = 1'b0;
    MemtoReg       = 1'b0;
    RegWrite       = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    Branch         = 1'b0;
    BranchEqual    = 1'b0;
    BranchNotEqual = 1'b0;
    Jump           = 1'b0;
    ALUOp          = 2'b00;
    PCWrite        = 1'b0;
    IRWrite        = 1'b0;
    retire         = 1'b0;
    illegal        = 1'b0;
    timeout        = 1'b0;
    case (state_r)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = rdy_s;
        PCWrite = rdy_s;
        timeout = tmo_s;
      end
      DECODE: begin
        if (dec_s == C_J) begin
          Jump    = 1'b1;
          PCWrite = 1'b1;
          retire  = 1'b1;
        end else if (dec_s == C_ILL) begin
          illegal = 1'b1;
        end else begin
          illegal = 1'b0;
        end
      end
      EXECUTE: begin
        case (class_r)
          C_RTYPE:             ALUOp = 2'b10;
          C_ADDI, C_LW, C_SW:  ALUSrc = 1'b1;
          C_BEQ: begin
            ALUOp       = 2'b01;
            Branch      = 1'b1;
            BranchEqual = 1'b1;
            retire      = 1'b1;
          end
          C_BNE: begin
            ALUOp          = 2'b01;
            Branch         = 1'b1;
            BranchNotEqual = 1'b1;
            retire         = 1'b1;
          end
          default: ALUOp = 2'b00;
        endcase
      end
      MEMORY: begin
        ALUSrc   = 1'b1;
        MemRead  = (class_r == C_LW);
        MemWrite = (class_r == C_SW);
        retire   = rdy_s & (class_r == C_SW);
        timeout  = tmo_s;
      end
      WRITEBACK: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        case (class_r)
          C_RTYPE: begin
            ALUOp  = 2'b10;
            RegDst = 1'b1;
          end
          C_ADDI: ALUSrc = 1'b1;
          C_LW: begin
            ALUSrc   = 1'b1;
            MemtoReg = 1'b1;
          end
          default: ALUOp = 2'b00;
        endcase
      end
      default: MemRead = 1'b0;
    endcase
  end

endmodule
